// File: rtl/stretch_chan.sv
// One channel of the programmable pulse stretcher.
// Widens a high level on in_lvl to len cycles, optionally retriggers,
// then optionally holds off for holdoff dead cycles. Also keeps a
// saturating count of stretched pulses (IDLE->STRETCH transitions).
//   clk, rst   : clock, asynchronous active-high reset
//   in_lvl     : channel input, synchronous level
//   len        : stretch length; 0 keeps the channel idle
//   holdoff    : dead cycles after each pulse
//   retrig     : 1 = IN during STRETCH reloads the countdown
//   cnt_clr    : synchronous clear of the pulse counter
//   out, busy  : registered stretched output / STRETCH-or-HOLD flag
//   count      : saturating pulse counter
module stretch_chan #(
  parameter int LW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_lvl,
  input  logic [LW-1:0] len,
  input  logic [LW-1:0] holdoff,
  input  logic          retrig,
  input  logic          cnt_clr,
  output logic          out,
  output logic          busy,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          trig;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_lvl && (len != '0)) begin
          state_d = STRETCH;
          cnt_d   = len - 1'b1;
          trig    = 1'b1;
        end
      end
      STRETCH: begin
        // Reload wins over both decrement and exit.
        if (retrig && in_lvl) begin
          cnt_d = len - 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (holdoff != '0) begin
          state_d = HOLD;
          cnt_d   = holdoff - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear coinciding with a new pulse leaves the counter at 1.
  always_comb begin
    if (cnt_clr) begin
      count_d = trig ? CW'(1) : '0;
    end else if (trig && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    out_d  = (state_d == STRETCH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out   = out_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: rtl/multi_stretch.sv
// Multi-channel run-time programmable pulse stretcher.
// NCH independent stretch_chan instances sharing LEN/HOLDOFF/RETRIG/CNT_CLR.
//   CLK, RST : clock, asynchronous active-high reset
//   IN       : per-channel synchronous level inputs
//   LEN      : stretch length in cycles (0 disables triggering)
//   HOLDOFF  : dead cycles after each stretched pulse
//   RETRIG   : retriggerable mode select
//   CNT_CLR  : synchronous clear of all pulse counters
//   OUT      : registered stretched outputs
//   BUSY     : registered per-channel STRETCH/HOLD flags
//   COUNT    : packed pulse counters, channel i at [i*CW +: CW]
module multi_stretch #(
  parameter int NCH = 4,
  parameter int LW  = 8,
  parameter int CW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    IN,
  input  logic [LW-1:0]     LEN,
  input  logic [LW-1:0]     HOLDOFF,
  input  logic              RETRIG,
  input  logic              CNT_CLR,
  output logic [NCH-1:0]    OUT,
  output logic [NCH-1:0]    BUSY,
  output logic [NCH*CW-1:0] COUNT
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    stretch_chan #(
      .LW (LW),
      .CW (CW)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .in_lvl  (IN[i]),
      .len     (LEN),
      .holdoff (HOLDOFF),
      .retrig  (RETRIG),
      .cnt_clr (CNT_CLR),
      .out     (OUT[i]),
      .busy    (BUSY[i]),
      .count   (COUNT[i*CW +: CW])
    );
  end

endmodule
